// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution: BHT indexing and the in-flight branch record.
// No logic of its own; pure declarations.
// No flow control; consumers own backpressure.
package branch_pkg;
    localparam int PC_W        = 32;
    localparam int BHT_IDX_W   = 5;
    localparam int BHT_IDX_LSB = 2;
    localparam logic [PC_W-1:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] target;
    } br_rec_t;
endpackage

// File: rtl/branch_fifo.sv
// In-order queue of in-flight branch records with a single-cycle flush.
// Head is a combinational read; push/pop/flush take effect on the next edge.
// Push while full is dropped; flush wins over a same-cycle push.
module branch_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  br_rec_t push_dat,
    input  logic    pop,
    input  logic    flush,
    output logic    full,
    output logic    empty,
    output br_rec_t head_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    br_rec_t            mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               do_push;
    logic               do_pop;

    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Queues fetch-time branch predictions, checks them at execute, updates the BHT and redirects on mispredict.
// Latency: BHT update, redirect and counters are registered, one cycle after ex_valid.
// Backpressure: fetch_stall while the queue is full; fetch must hold its branch.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic                 fetch_is_branch,
    input  logic [PC_W-1:0]      fetch_pc,
    input  logic                 prediction,
    input  logic [PC_W-1:0]      fetch_target,
    output logic                 fetch_stall,
    input  logic                 ex_valid,
    input  logic                 ex_taken,
    input  logic [PC_W-1:0]      ex_target,
    output logic                 bht_we,
    output logic [BHT_IDX_W-1:0] bht_write_addr,
    output logic                 bht_was_taken,
    output logic                 redirect_valid,
    output logic [PC_W-1:0]      redirect_pc,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count,
    output logic                 underflow_err
);
    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    mispredict;
    logic    flush;
    br_rec_t push_rec;
    br_rec_t head;

    assign push_rec    = '{pc: fetch_pc, pred: prediction, target: fetch_target};
    assign push        = fetch_valid & fetch_is_branch & ~full;
    assign pop         = ex_valid & ~empty;
    assign mispredict  = (ex_taken != head.pred) |
                         (ex_taken & head.pred & (ex_target != head.target));
    // Everything younger than a mispredicted branch is wrong-path, including this cycle's fetch.
    assign flush       = pop & mispredict;
    assign fetch_stall = full;

    branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_rec),
        .pop      (pop),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .head_dat (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht_we           <= 1'b0;
            bht_write_addr   <= '0;
            bht_was_taken    <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            underflow_err    <= 1'b0;
        end else begin
            bht_we         <= pop;
            redirect_valid <= flush;
            if (pop) begin
                bht_write_addr <= head.pc[BHT_IDX_LSB +: BHT_IDX_W];
                bht_was_taken  <= ex_taken;
                if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
            end
            if (flush) begin
                redirect_pc <= ex_taken ? ex_target : head.pc + PC_INCR;
                if (mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
            end
            if (ex_valid && empty) underflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and random stimulus for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_is_branch = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        prediction = 1'b0;
    logic [31:0] fetch_target = '0;
    logic        fetch_stall;
    logic        ex_valid = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        bht_we;
    logic [4:0]  bht_write_addr;
    logic        bht_was_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;
    logic        underflow_err;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_is_branch  (fetch_is_branch),
        .fetch_pc         (fetch_pc),
        .prediction       (prediction),
        .fetch_target     (fetch_target),
        .fetch_stall      (fetch_stall),
        .ex_valid         (ex_valid),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .bht_we           (bht_we),
        .bht_write_addr   (bht_write_addr),
        .bht_was_taken    (bht_was_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .underflow_err    (underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } mrec_t;

    mrec_t       mq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        e_we, e_wt, e_rv, e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_rpc;
    logic [15:0] e_bc, e_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_we = 0; e_wt = 0; e_rv = 0; e_err = 0;
        e_addr = '0; e_rpc = '0; e_bc = '0; e_mc = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bht_we"},   32'(bht_we),           32'(e_we));
        chk({tag, ".addr"},     32'(bht_write_addr),   32'(e_addr));
        chk({tag, ".taken"},    32'(bht_was_taken),    32'(e_wt));
        chk({tag, ".redir_v"},  32'(redirect_valid),   32'(e_rv));
        chk({tag, ".redir_pc"}, redirect_pc,           e_rpc);
        chk({tag, ".br_cnt"},   32'(branch_count),     32'(e_bc));
        chk({tag, ".mp_cnt"},   32'(mispredict_count), 32'(e_mc));
        chk({tag, ".uflow"},    32'(underflow_err),    32'(e_err));
        chk({tag, ".stall"},    32'(fetch_stall),      32'(mq.size() == DEPTH));
    endtask

    // One clock: model the edge from the inputs currently driven, then check after the edge.
    task automatic step(input string tag);
        bit    stall_pre;
        bit    flushed;
        mrec_t h;
        bit    mis;
        stall_pre = (mq.size() == DEPTH);
        flushed = 0;
        @(posedge clk);
        e_we = 0;
        e_rv = 0;
        if (ex_valid) begin
            if (mq.size() == 0) begin
                e_err = 1;
            end else begin
                h = mq.pop_front();
                mis = (ex_taken != h.pred) || (ex_taken && ex_target != h.tgt);
                e_we = 1;
                e_addr = h.pc[6:2];
                e_wt = ex_taken;
                if (e_bc != 16'hFFFF) e_bc = e_bc + 1;
                if (mis) begin
                    e_rv = 1;
                    e_rpc = ex_taken ? ex_target : h.pc + 32'd4;
                    if (e_mc != 16'hFFFF) e_mc = e_mc + 1;
                    mq.delete();
                    flushed = 1;
                end
            end
        end
        if (fetch_valid && fetch_is_branch && !stall_pre && !flushed)
            mq.push_back('{pc: fetch_pc, pred: prediction, tgt: fetch_target});
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic fv, input logic fb, input logic [31:0] pc, input logic pr,
                         input logic [31:0] tg, input logic ev, input logic et, input logic [31:0] etg,
                         input string tag);
        fetch_valid = fv; fetch_is_branch = fb; fetch_pc = pc; prediction = pr; fetch_target = tg;
        ex_valid = ev; ex_taken = et; ex_target = etg;
        step(tag);
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, tag);
    endtask

    initial begin
        int guard;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle("idle");

        // Correctly predicted taken branch
        drive(1, 1, 32'h40, 1, 32'h100, 0, 0, 32'h0, "enq40");
        drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h100, "res40");
        chk("res40.addr16", 32'(bht_write_addr), 32'd16);
        chk("res40.bc1", 32'(branch_count), 32'd1);
        idle("res40.after");

        // Direction mispredict flushes younger entries
        drive(1, 1, 32'h08, 1, 32'h80, 0, 0, 32'h0, "enq08");
        drive(1, 1, 32'h10, 1, 32'h90, 0, 0, 32'h0, "enq10");
        drive(1, 1, 32'h14, 0, 32'h0,  0, 0, 32'h0, "enq14");
        drive(1, 1, 32'h18, 0, 32'h0,  1, 0, 32'h0, "res08");
        chk("res08.rpc", redirect_pc, 32'h0000_000C);
        chk("res08.addr2", 32'(bht_write_addr), 32'd2);
        chk("res08.mc1", 32'(mispredict_count), 32'd1);
        drive(1, 1, 32'h20, 0, 32'h0, 0, 0, 32'h0, "enq20");
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, "res20");
        chk("res20.addr8", 32'(bht_write_addr), 32'd8);

        // Target mispredict on a taken branch
        drive(1, 1, 32'h7C, 1, 32'h200, 0, 0, 32'h0, "enq7c");
        drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h300, "res7c");
        chk("res7c.rpc", redirect_pc, 32'h300);
        chk("res7c.addr31", 32'(bht_write_addr), 32'd31);

        // Fill to full, try a fifth push, free one slot
        for (int i = 0; i < DEPTH; i++)
            drive(1, 1, 32'h100 + 32'(i * 4), 1, 32'h400, 0, 0, 32'h0, "fill");
        chk("full.stall", 32'(fetch_stall), 32'd1);
        drive(1, 1, 32'h1F0, 1, 32'h400, 0, 0, 32'h0, "push5");
        drive(1, 1, 32'h1F4, 1, 32'h400, 1, 1, 32'h400, "deq_full");
        chk("freed.stall", 32'(fetch_stall), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++)
            drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h400, "drain");
        drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h400, "uflow");
        chk("uflow.err", 32'(underflow_err), 32'd1);
        chk("uflow.we", 32'(bht_we), 32'd0);
        idle("uflow.sticky");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] etg;
            etg = ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h100;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) etg = mq[0].tgt;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h100,
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), etg, "rand");
        end

        // Reset during a redirect pulse
        drive(1, 1, 32'h50, 1, 32'h500, 0, 0, 32'h0, "pre_rst.enq");
        drive(1, 1, 32'h54, 1, 32'h500, 1, 0, 32'h0, "pre_rst.mis");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        idle("post_rst");

        // Saturate branch_count with a steady stream of correct resolves
        drive(1, 1, 32'h60, 0, 32'h0, 0, 0, 32'h0, "sat.prime");
        guard = 0;
        while (e_bc != 16'hFFFF && guard < 70000) begin
            drive(1, 1, 32'h60, 0, 32'h0, 1, 0, 32'h0, "sat");
            guard++;
        end
        chk("sat.reached", 32'(guard < 70000), 32'd1);
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, "sat.extra");
        chk("sat.hold", 32'(branch_count), 32'h0000_FFFF);
        chk("sat.mc", 32'(mispredict_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
